// File: rtl/dram_tester_if.sv
// Avalon-MM initiator bus between dram_tester and the SDRAM controller slave port.
interface dram_tester_if #(
    parameter int unsigned ADDR_W = 24
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [15:0]       avm_writedata;
    logic [1:0]        avm_byteenable;
    logic              avm_read;
    logic [15:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_byteenable, avm_read,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_byteenable, avm_read,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/dram_tester.sv
// SDRAM self-test: writes an address-derived pattern over 0..N_WORDS-1, then reads it
// back with up to MAX_PEND pipelined reads and counts mismatching words.
module dram_tester #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned N_WORDS  = 1024,
    parameter logic [15:0] SEED     = 16'hA5C3,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr,
    dram_tester_if.master     avm
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [3:0]        MAX_P  = 4'(MAX_PEND);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wa_q, wa_d, ia_q, ia_d, ra_q, ra_d;
    logic [3:0]        pend_q, pend_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              write_q, write_d, read_q, read_d;

    logic wr_acc, rd_acc, ret, mism;

    function automatic logic [15:0] pat(input logic [ADDR_W-1:0] a);
        return 16'(a) ^ SEED;
    endfunction

    assign wr_acc = write_q && !avm.avm_waitrequest;
    assign rd_acc = read_q && !avm.avm_waitrequest;
    assign ret    = avm.avm_readdatavalid;
    assign mism   = ret && (avm.avm_readdata != pat(ra_q));

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wa_q        <= '0;
            ia_q        <= '0;
            ra_q        <= '0;
            pend_q      <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wa_q        <= wa_d;
            ia_q        <= ia_d;
            ra_q        <= ra_d;
            pend_q      <= pend_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            read_q      <= read_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        wa_d        = wa_q;
        ia_d        = ia_q;
        ra_d        = ra_q;
        pend_d      = pend_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        done_d      = done_q;
        pass_d      = pass_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        read_d      = read_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    wa_d        = '0;
                    ia_d        = '0;
                    ra_d        = '0;
                    pend_d      = '0;
                    err_count_d = '0;
                    err_addr_d  = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    addr_d      = '0;
                    wdata_d     = pat('0);
                    write_d     = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    if (wa_q == LAST_A) begin
                        state_d = S_READ;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        addr_d  = '0;
                        ia_d    = '0;
                        ra_d    = '0;
                        pend_d  = '0;
                    end else begin
                        wa_d    = wa_q + ONE_A;
                        addr_d  = wa_q + ONE_A;
                        wdata_d = pat(wa_q + ONE_A);
                    end
                end
            end
            S_READ, S_DRAIN: begin
                if (ret) begin
                    ra_d = ra_q + ONE_A;
                    if (mism) begin
                        if (err_count_q == 16'd0) err_addr_d = ra_q;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                    end
                end
                pend_d = pend_q + {3'b000, rd_acc} - {3'b000, ret};
                if (state_q == S_READ) begin
                    if (rd_acc) ia_d = ia_q + ONE_A;
                    if (rd_acc && (ia_q == LAST_A)) begin
                        state_d = S_DRAIN;
                        read_d  = 1'b0;
                    end else begin
                        // Throttle on the post-edge count so read never exceeds MAX_PEND in flight
                        read_d = (pend_d < MAX_P);
                        addr_d = ia_d;
                    end
                end else if (ret && (ra_q == LAST_A)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == 16'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

    assign avm.avm_address    = addr_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 2'b11;
    assign avm.avm_read       = read_q;

endmodule

// File: tb/tb_dram_tester.sv
// Randomized bench for dram_tester: Avalon slave memory model with configurable stall/latency
// and corruption, plus scoreboards for the write stream and the end-of-run result.
module tb_dram_tester;
    localparam int unsigned AW   = 24;
    localparam int unsigned NW   = 16;
    localparam int unsigned MAXP = 4;
    localparam logic [15:0] SEED = 16'hA5C3;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] err_addr;

    dram_tester_if #(.ADDR_W(AW)) avm ();

    dram_tester #(.ADDR_W(AW), .N_WORDS(NW), .SEED(SEED), .MAX_PEND(MAXP)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .err_addr(err_addr), .avm(avm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Slave model state
    typedef struct {int due; int addr;} rd_t;
    typedef struct {logic [AW-1:0] addr; logic [15:0] data;} wr_t;
    typedef struct {logic ok; logic [15:0] cnt; logic [AW-1:0] addr;} res_t;

    int          cyc = 0;
    int          lat = 2;
    int          stall_pct = 0;
    bit [NW-1:0] corrupt_mask = '0;
    logic [15:0] mem [NW];
    rd_t         pipe [$];
    wr_t         exp_wr [$];
    res_t        res_q [$];
    int          outs = 0;
    int          max_outs = 0;
    int          nwrites = 0;

    always @(posedge clk) cyc++;

    // Slave: drives the handshake for the upcoming edge shortly after each edge
    initial begin
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata      = '0;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            #2;
            begin
                int  a;
                bit  wr;
                avm.avm_readdatavalid = 1'b0;
                if (pipe.size() > 0 && pipe[0].due <= cyc + 1) begin
                    a = pipe[0].addr;
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata = (a < NW) ? (mem[a] ^ {15'b0, corrupt_mask[a]}) : 16'h0;
                    void'(pipe.pop_front());
                end
                wr = (($urandom % 100) < stall_pct);
                avm.avm_waitrequest = wr;
                a = int'(avm.avm_address);
                if (!reset && !wr && avm.avm_write && a < NW) mem[a] = avm.avm_writedata;
                if (!reset && !wr && avm.avm_read) pipe.push_back('{cyc + 1 + lat, a});
            end
        end
    end

    // Write-stream / outstanding-read monitor
    logic          prev_stall_wr = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [15:0]   prev_data;
    always @(negedge clk) begin
        if (reset) begin
            outs = 0;
            prev_stall_wr = 1'b0;
        end else begin
            if (prev_stall_wr) begin
                check("hold_write", avm.avm_write, 1);
                check("hold_addr", avm.avm_address, prev_addr);
                check("hold_data", avm.avm_writedata, prev_data);
            end
            if (busy) begin
                check("rd_wr_exclusive", avm.avm_read & avm.avm_write, 0);
                check("pend_over_max", outs > MAXP, 0);
                if (outs == MAXP) check("read_low_at_max", avm.avm_read, 0);
            end
            if (avm.avm_write && !avm.avm_waitrequest) begin
                nwrites++;
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", avm.avm_address, e.addr);
                    check("wr_data", avm.avm_writedata, e.data);
                end
            end
            if (avm.avm_read && !avm.avm_waitrequest) outs++;
            if (avm.avm_readdatavalid && outs > 0) outs--;
            if (outs > max_outs) max_outs = outs;
            prev_stall_wr = avm.avm_write && avm.avm_waitrequest;
            prev_addr = avm.avm_address;
            prev_data = avm.avm_writedata;
        end
    end

    // Result scoreboard: compares each done rising edge against the queued expectation
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) done_prev = 1'b0;
        else begin
            if (done && !done_prev) begin
                if (res_q.size() == 0) fail_now("unexpected_done");
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("res_pass", pass, r.ok);
                    check("res_err_count", err_count, r.cnt);
                    check("res_err_addr", err_addr, r.addr);
                end
            end
            done_prev = done;
        end
    end

    // Reference: every address written once in order; errors are the corrupted addresses
    task automatic push_expect(input bit [NW-1:0] cm);
        res_t r;
        int   n, first;
        n = 0;
        first = -1;
        for (int a = 0; a < NW; a++) begin
            exp_wr.push_back('{AW'(a), 16'(a) ^ SEED});
            if (cm[a]) begin
                n++;
                if (first < 0) first = a;
            end
        end
        r.ok = (n == 0);
        r.cnt = 16'(n);
        r.addr = (first < 0) ? '0 : AW'(first);
        res_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int l, input int sp, input bit [NW-1:0] cm, input bit mid, output int dcyc);
        int s_cyc, t;
        lat = l;
        stall_pct = sp;
        corrupt_mask = cm;
        max_outs = 0;
        nwrites = 0;
        push_expect(cm);
        pulse_start();
        s_cyc = cyc;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_pass_clr", pass, 0);
        check("start_err_clr", err_count, 0);
        check("start_write_hi", avm.avm_write, 1);
        if (mid) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!done) fail_now("done_timeout");
        dcyc = cyc - s_cyc;
        repeat (2) @(negedge clk);
        check("write_count", nwrites, NW);
        check("res_consumed", res_q.size(), 0);
        check("done_held", done, 1);
        check("busy_low_done", busy, 0);
    endtask

    initial begin
        int d, t;
        reset = 1'b0;
        start = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_address", avm.avm_address, 0);
        check("rst_write", avm.avm_write, 0);
        check("rst_writedata", avm.avm_writedata, 0);
        check("rst_read", avm.avm_read, 0);
        check("rst_byteenable", avm.avm_byteenable, 2'b11);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal slave, latency 2
        run(2, 0, '0, 1'b0, d);
        check("ideal_cycles_in_window", (d >= 34 && d <= 36), 1);
        check("word3_pattern", mem[3], 16'hA5C0);

        // 50% waitrequest
        run(2, 50, '0, 1'b0, d);

        // Latency 8 saturates the outstanding-read window
        run(8, 0, '0, 1'b0, d);
        check("pend_reached_max", max_outs, MAXP);

        // Corrupt addresses 5 and 9
        run(2, 0, NW'(16'h0220), 1'b0, d);

        // start during WRITE is ignored; start in DONE clears the error count
        run(3, 20, '0, 1'b1, d);

        // Reset mid-READ with 3 reads outstanding
        lat = 8;
        stall_pct = 0;
        corrupt_mask = '0;
        push_expect('0);
        pulse_start();
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (outs != 3 && t < 200);
        if (outs != 3) fail_now("reset_window_not_reached");
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_read", avm.avm_read, 0);
        check("mid_rst_write", avm.avm_write, 0);
        check("mid_rst_address", avm.avm_address, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_byteenable", avm.avm_byteenable, 2'b11);
        res_q.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("stale_busy", busy, 0);
        check("stale_done", done, 0);
        check("stale_err_count", err_count, 0);
        check("stale_read", avm.avm_read, 0);
        run(3, 0, '0, 1'b0, d);

        // Randomized runs
        for (int i = 0; i < 6; i++) begin
            bit [NW-1:0] cm;
            cm = NW'($urandom & $urandom & $urandom);
            run($urandom_range(1, 10), $urandom_range(0, 60), cm, 1'($urandom % 2), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
